// File: rtl/pkt_proto_pkg.sv
// pkt_proto_pkg: frame constants, FSM states and length clamp shared by the tx framer and rx parser
package pkt_proto_pkg;
    localparam int HDR_BYTES   = 4;
    localparam int MAX_PAYLOAD = 4;
    localparam int LEN_W       = 3;
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_HDR, ST_PAY, ST_CSUM} state_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return len > LEN_W'(MAX_PAYLOAD) ? LEN_W'(MAX_PAYLOAD) : len;
    endfunction
endpackage

// File: rtl/pkt_tx_framer_if.sv
// pkt_tx_framer_if: request fields in, byte stream and status strobes out
interface pkt_tx_framer_if;
    logic                             SEND_VALID;
    logic                             SEND_READY;
    logic [7:0]                       SEQ_NUM;
    logic [7:0]                       ACK_NUM;
    logic [7:0]                       FLAGS;
    logic [pkt_proto_pkg::LEN_W-1:0]  PAYLOAD_LEN;
    logic [31:0]                      PAYLOAD_DATA;
    logic [7:0]                       TX_DATA;
    logic                             TX_VALID;
    logic                             TX_READY;
    logic                             TX_LAST;
    logic                             FRAME_DONE;
    logic                             LEN_ERR;
    logic                             TX_LED;

    modport master (
        output SEND_VALID, SEQ_NUM, ACK_NUM, FLAGS, PAYLOAD_LEN, PAYLOAD_DATA, TX_READY,
        input  SEND_READY, TX_DATA, TX_VALID, TX_LAST, FRAME_DONE, LEN_ERR, TX_LED
    );
    modport slave (
        input  SEND_VALID, SEQ_NUM, ACK_NUM, FLAGS, PAYLOAD_LEN, PAYLOAD_DATA, TX_READY,
        output SEND_READY, TX_DATA, TX_VALID, TX_LAST, FRAME_DONE, LEN_ERR, TX_LED
    );
endinterface

// File: rtl/pkt_csum8.sv
// pkt_csum8: 8-bit wrap-around sum with synchronous clear and add enable
module pkt_csum8 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       i_clr,
    input  logic       i_add,
    input  logic [7:0] i_byte,
    output logic [7:0] o_sum
);
    logic [7:0] r_acc;

    always_ff @(posedge CLK) begin
        if (RESET || i_clr) r_acc <= 8'h00;
        else if (i_add)     r_acc <= r_acc + i_byte;
    end

    assign o_sum = r_acc;
endmodule

// File: rtl/pkt_tx_framer.sv
// pkt_tx_framer: serializes one packet's fields into SOF/header/payload/checksum bytes
// with a registered valid/ready output stage and a stretched activity LED.
module pkt_tx_framer
    import pkt_proto_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE = SOF_DEFAULT,
    parameter bit          CSUM_EN  = 1'b1,
    parameter int unsigned LED_HOLD = 50_000_000
) (
    input  logic           CLK,
    input  logic           RESET,
    pkt_tx_framer_if.slave bus
);
    state_t           r_state;
    logic [1:0]       r_idx;
    logic [7:0]       r_seq, r_ack, r_flags;
    logic [LEN_W-1:0] r_len;
    logic [31:0]      r_data;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid, r_tx_last, r_done, r_len_err;
    logic [25:0]      r_led_cnt;
    logic [7:0]       w_sum, w_csum_fin;
    logic             w_accept, w_hs, w_last_hs, w_pay_end;

    assign w_accept   = bus.SEND_VALID && r_state == ST_IDLE;
    assign w_hs       = r_tx_valid && bus.TX_READY;
    assign w_last_hs  = w_hs && r_tx_last;
    assign w_pay_end  = {1'b0, r_idx} == r_len - LEN_W'(1);
    // Final checksum must include the byte handshaking this cycle.
    assign w_csum_fin = w_sum + r_tx_data;

    pkt_csum8 u_csum (
        .CLK    (CLK),
        .RESET  (RESET),
        .i_clr  (w_accept),
        .i_add  (w_hs && (r_state == ST_HDR || r_state == ST_PAY)),
        .i_byte (r_tx_data),
        .o_sum  (w_sum)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_done     <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_done    <= w_last_hs;
            r_len_err <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.SEND_VALID) begin
                    r_seq      <= bus.SEQ_NUM;
                    r_ack      <= bus.ACK_NUM;
                    r_flags    <= bus.FLAGS;
                    r_len      <= clamp_len(bus.PAYLOAD_LEN);
                    r_data     <= bus.PAYLOAD_DATA;
                    r_len_err  <= bus.PAYLOAD_LEN > LEN_W'(MAX_PAYLOAD);
                    r_tx_data  <= SOF_BYTE;
                    r_tx_valid <= 1'b1;
                    r_tx_last  <= 1'b0;
                    r_state    <= ST_SOF;
                end
                ST_SOF: if (w_hs) begin
                    r_state   <= ST_HDR;
                    r_idx     <= 2'd0;
                    r_tx_data <= r_seq;
                end
                ST_HDR: if (w_hs) begin
                    if (r_idx != 2'(HDR_BYTES - 1)) begin
                        r_idx     <= r_idx + 2'd1;
                        r_tx_data <= r_idx == 2'd0 ? r_ack : r_idx == 2'd1 ? r_flags : {{(8-LEN_W){1'b0}}, r_len};
                        r_tx_last <= r_idx == 2'd2 && !CSUM_EN && r_len == '0;
                    end else if (r_len != '0) begin
                        r_state   <= ST_PAY;
                        r_idx     <= 2'd0;
                        r_tx_data <= r_data[31:24];
                        r_data    <= {r_data[23:0], 8'h00};
                        r_tx_last <= !CSUM_EN && r_len == LEN_W'(1);
                    end else if (CSUM_EN) begin
                        r_state   <= ST_CSUM;
                        r_tx_data <= w_csum_fin;
                        r_tx_last <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_tx_valid <= 1'b0;
                        r_tx_last  <= 1'b0;
                    end
                end
                ST_PAY: if (w_hs) begin
                    r_idx <= r_idx + 2'd1;
                    if (!w_pay_end) begin
                        r_tx_data <= r_data[31:24];
                        r_data    <= {r_data[23:0], 8'h00};
                        r_tx_last <= !CSUM_EN && ({1'b0, r_idx} + LEN_W'(2) == r_len);
                    end else if (CSUM_EN) begin
                        r_state   <= ST_CSUM;
                        r_tx_data <= w_csum_fin;
                        r_tx_last <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_tx_valid <= 1'b0;
                        r_tx_last  <= 1'b0;
                    end
                end
                ST_CSUM: if (w_hs) begin
                    r_state    <= ST_IDLE;
                    r_tx_valid <= 1'b0;
                    r_tx_last  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Loading on the final handshake makes the LED rise together with FRAME_DONE.
    always_ff @(posedge CLK) begin
        if (RESET)               r_led_cnt <= '0;
        else if (w_last_hs)      r_led_cnt <= 26'(LED_HOLD);
        else if (r_led_cnt != 0) r_led_cnt <= r_led_cnt - 26'd1;
    end

    assign bus.SEND_READY = r_state == ST_IDLE;
    assign bus.TX_DATA    = r_tx_data;
    assign bus.TX_VALID   = r_tx_valid;
    assign bus.TX_LAST    = r_tx_last;
    assign bus.FRAME_DONE = r_done;
    assign bus.LEN_ERR    = r_len_err;
    assign bus.TX_LED     = r_led_cnt != '0;
endmodule
